// File: rtl/traffic_mon_pkg.sv
// Shared encodings for the traffic-light monitor: states, phases, lamp vectors, fault codes.
// Also holds the parameter defaults and small decode helpers used by the monitor.
package traffic_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RED    = 3'd1,
        ST_GREEN  = 3'd2,
        ST_YELLOW = 3'd3,
        ST_FAULT  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        TMR_HOLD  = 2'd0,
        TMR_ZERO  = 2'd1,
        TMR_LOAD1 = 2'd2,
        TMR_INC   = 2'd3
    } tmr_op_e;

    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_RED    = 2'd1;
    localparam logic [1:0] PH_GREEN  = 2'd2;
    localparam logic [1:0] PH_YELLOW = 2'd3;

    // Lamp vectors are ordered {r, g, y}
    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_G   = 3'b010;
    localparam logic [2:0] LAMP_Y   = 3'b001;

    localparam logic [2:0] FC_NONE    = 3'd0;
    localparam logic [2:0] FC_MULTI   = 3'd1;
    localparam logic [2:0] FC_ORDER   = 3'd2;
    localparam logic [2:0] FC_SHORT   = 3'd3;
    localparam logic [2:0] FC_TIMEOUT = 3'd4;
    localparam logic [2:0] FC_ALLOFF  = 3'd5;

    localparam logic [7:0] R_MIN_DEF = 8'd4;
    localparam logic [7:0] G_MIN_DEF = 8'd4;
    localparam logic [7:0] Y_MIN_DEF = 8'd2;
    localparam logic [7:0] T_MAX_DEF = 8'd200;

    function automatic logic [2:0] lamp_of(state_e s);
        case (s)
            ST_RED:    lamp_of = LAMP_R;
            ST_GREEN:  lamp_of = LAMP_G;
            ST_YELLOW: lamp_of = LAMP_Y;
            default:   lamp_of = LAMP_OFF;
        endcase
    endfunction

    function automatic state_e next_of(state_e s);
        case (s)
            ST_RED:    next_of = ST_GREEN;
            ST_GREEN:  next_of = ST_YELLOW;
            ST_YELLOW: next_of = ST_RED;
            default:   next_of = ST_FAULT;
        endcase
    endfunction

    function automatic logic [1:0] phase_of(state_e s);
        case (s)
            ST_RED:    phase_of = PH_RED;
            ST_GREEN:  phase_of = PH_GREEN;
            ST_YELLOW: phase_of = PH_YELLOW;
            default:   phase_of = PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating 8-bit phase-duration counter: hold, clear to 0, load 1 on phase entry, increment.
// Latency: count visible the cycle after the op; no backpressure, op applied every cycle.
module phase_timer
    import traffic_mon_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  tmr_op_e    op,
    output logic [7:0] cnt
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        case (op)
            TMR_ZERO:  cnt_d = 8'd0;
            TMR_LOAD1: cnt_d = 8'd1;
            TMR_INC:   cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            default:   cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/traffic_monitor.sv
// Traffic-light sequence monitor: checks lamp order, phase minimums and timeout; 1-cycle output latency.
// No backpressure (pure observer). TRAFFIC_MON_STICKY_FAULT_EN keeps FAULT until reset.
module traffic_monitor
    import traffic_mon_pkg::*;
#(
    parameter logic [7:0] R_MIN = R_MIN_DEF,
    parameter logic [7:0] G_MIN = G_MIN_DEF,
    parameter logic [7:0] Y_MIN = Y_MIN_DEF,
    parameter logic [7:0] T_MAX = T_MAX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       r,
    input  logic       g,
    input  logic       y,
    output logic [1:0] phase,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] dur_last
);

    state_e     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic       fault_q, fault_d;
    logic [2:0] fault_code_q, fault_code_d;
    logic [7:0] dur_last_q, dur_last_d;

    tmr_op_e    tmr_op;
    logic [7:0] cnt;
    logic [2:0] lamps;
    logic       multi_on;
    logic [7:0] min_left;
    logic [2:0] fc;

    phase_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .op    (tmr_op),
        .cnt   (cnt)
    );

    assign lamps    = {r, g, y};
    assign multi_on = (r & g) | (r & y) | (g & y);

    always_comb begin
        case (state_q)
            ST_RED:    min_left = R_MIN;
            ST_GREEN:  min_left = G_MIN;
            ST_YELLOW: min_left = Y_MIN;
            default:   min_left = 8'd0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        dur_last_d   = dur_last_q;
        tmr_op       = TMR_HOLD;
        fc           = FC_NONE;

        case (state_q)
            ST_IDLE: begin
                tmr_op = TMR_ZERO;
                if (multi_on) begin
                    fc = FC_MULTI;
                end else if (lamps == LAMP_R) begin
                    state_d = ST_RED;
                    tmr_op  = TMR_LOAD1;
                end else if (lamps != LAMP_OFF) begin
                    fc = FC_ORDER;
                end
            end
            ST_RED, ST_GREEN, ST_YELLOW: begin
                // Branch order encodes fault priority; timeout only applies to an unchanged lamp
                if (multi_on) begin
                    fc = FC_MULTI;
                end else if (lamps == LAMP_OFF) begin
                    fc = FC_ALLOFF;
                end else if (lamps == lamp_of(state_q)) begin
                    if (({1'b0, cnt} + 9'd1) == {1'b0, T_MAX}) begin
                        fc = FC_TIMEOUT;
                    end else begin
                        tmr_op = TMR_INC;
                    end
                end else if (lamps != lamp_of(next_of(state_q))) begin
                    fc = FC_ORDER;
                end else if (cnt < min_left) begin
                    fc = FC_SHORT;
                end else begin
                    state_d    = next_of(state_q);
                    dur_last_d = cnt;
                    tmr_op     = TMR_LOAD1;
                end
            end
            ST_FAULT: begin
                tmr_op = TMR_ZERO;
`ifdef TRAFFIC_MON_STICKY_FAULT_EN
                state_d = ST_FAULT;
`else
                if (lamps == LAMP_R) begin
                    state_d = ST_RED;
                    tmr_op  = TMR_LOAD1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                tmr_op  = TMR_ZERO;
            end
        endcase

        if (fc != FC_NONE) begin
            state_d      = ST_FAULT;
            fault_code_d = fc;
            dur_last_d   = dur_last_q;
            tmr_op       = TMR_ZERO;
        end

        phase_d = phase_of(state_d);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_IDLE;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            dur_last_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            dur_last_q   <= dur_last_d;
        end
    end

    assign phase      = phase_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign dur_last   = dur_last_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor: legal cycle, short phase, multi-lamp, timeout, order, reset.
module tb_traffic_monitor;

    logic       clk;
    logic       reset;
    logic       r, g, y;
    logic [1:0] phase;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] dur_last;

    int n_chk;
    int n_err;
    logic any_fault;

    localparam logic [2:0] L_OFF = 3'b000;
    localparam logic [2:0] L_R   = 3'b100;
    localparam logic [2:0] L_G   = 3'b010;
    localparam logic [2:0] L_Y   = 3'b001;
    localparam logic [2:0] L_RG  = 3'b110;

    traffic_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .r          (r),
        .g          (g),
        .y          (y),
        .phase      (phase),
        .fault      (fault),
        .fault_code (fault_code),
        .dur_last   (dur_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one lamp vector for one clock edge, then sample just after the edge
    task automatic step(input logic [2:0] v);
        {r, g, y} = v;
        @(posedge clk);
        #1;
        any_fault = any_fault | fault;
    endtask

    task automatic run(input logic [2:0] v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic do_reset();
        {r, g, y} = L_OFF;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        any_fault = 1'b0;
        {r, g, y} = L_OFF;
        reset     = 1'b1;
        #3;
        check("rst_phase", 32'(phase), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_code", 32'(fault_code), 0);
        check("rst_dur", 32'(dur_last), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Legal cycle red 4, green 4, yellow 2, back to red
        any_fault = 1'b0;
        step(L_R);    check("a_ph_red", 32'(phase), 1);
        run(L_R, 3);  check("a_ph_red4", 32'(phase), 1);
        step(L_G);    check("a_ph_green", 32'(phase), 2);
                      check("a_dur_red", 32'(dur_last), 4);
        run(L_G, 3);
        step(L_Y);    check("a_ph_yellow", 32'(phase), 3);
                      check("a_dur_green", 32'(dur_last), 4);
        run(L_Y, 1);
        step(L_R);    check("a_ph_red2", 32'(phase), 1);
                      check("a_dur_yellow", 32'(dur_last), 2);
        check("a_no_fault", 32'(any_fault), 0);

        // Short green: red 4, green 2, then yellow
        run(L_R, 3);
        step(L_G);    check("b_ph_green", 32'(phase), 2);
        run(L_G, 1);
        step(L_Y);    check("b_fault", 32'(fault), 1);
                      check("b_code", 32'(fault_code), 3);
                      check("b_phase", 32'(phase), 0);
                      check("b_dur", 32'(dur_last), 4);

        // Two lamps during green
        do_reset();
        run(L_R, 4);
        run(L_G, 2);
        step(L_RG);   check("c_code", 32'(fault_code), 1);
                      check("c_fault", 32'(fault), 1);
                      check("c_phase", 32'(phase), 0);
        step(L_R);
`ifdef TRAFFIC_MON_STICKY_FAULT_EN
        check("c_sticky_fault", 32'(fault), 1);
        check("c_sticky_phase", 32'(phase), 0);
`else
        check("c_rec_phase", 32'(phase), 1);
        check("c_rec_fault", 32'(fault), 0);
`endif
        check("c_code_held", 32'(fault_code), 1);

        // Timeout: green held for 200 cycles
        do_reset();
        run(L_R, 4);
        run(L_G, 199); check("d_pre_fault", 32'(fault), 0);
                       check("d_pre_phase", 32'(phase), 2);
        step(L_G);     check("d_code", 32'(fault_code), 4);
                       check("d_fault", 32'(fault), 1);
                       check("d_dur", 32'(dur_last), 4);

        // Yellow first out of IDLE
        do_reset();
        step(L_OFF);  check("e_idle_phase", 32'(phase), 0);
                      check("e_idle_fault", 32'(fault), 0);
        step(L_Y);    check("e_code", 32'(fault_code), 2);
                      check("e_fault", 32'(fault), 1);
        run(L_R, 3);
`ifdef TRAFFIC_MON_STICKY_FAULT_EN
        check("e_sticky_fault", 32'(fault), 1);
`else
        check("e_rec_fault", 32'(fault), 0);
        check("e_rec_phase", 32'(phase), 1);
`endif
        do_reset();
        check("e_rst_fault", 32'(fault), 0);
        check("e_rst_code", 32'(fault_code), 0);

        // Reset pulsed between edges mid-green
        run(L_R, 4);
        run(L_G, 2);  check("f_ph_green", 32'(phase), 2);
        #2;
        reset = 1'b1;
        #1;
        check("f_rst_phase", 32'(phase), 0);
        check("f_rst_fault", 32'(fault), 0);
        check("f_rst_code", 32'(fault_code), 0);
        check("f_rst_dur", 32'(dur_last), 0);
        #1;
        reset = 1'b0;
        step(L_OFF);  check("f_idle_phase", 32'(phase), 0);
        step(L_R);    check("f_red_phase", 32'(phase), 1);
        run(L_R, 3);
        step(L_G);    check("f_dur_red", 32'(dur_last), 4);

        // All lamps off mid-red
        do_reset();
        run(L_R, 2);
        step(L_OFF);  check("g_code", 32'(fault_code), 5);
                      check("g_fault", 32'(fault), 1);

        // Green to red skips yellow
        do_reset();
        run(L_R, 4);
        run(L_G, 4);
        step(L_R);    check("h_code", 32'(fault_code), 2);
                      check("h_dur", 32'(dur_last), 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
